// File: rtl/ps2_pkg.sv
// Shared PS/2 host definitions: transmitter states, keyboard command
// bytes and the frame parity helper.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INHIBIT   = 3'd1,
        ST_RTS       = 3'd2,
        ST_SEND      = 3'd3,
        ST_ACK       = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } ps2_state_e;

    localparam logic [7:0] CMD_SET_LED = 8'hED;
    localparam logic [7:0] CMD_RESET   = 8'hFF;
    localparam logic [7:0] CMD_ENABLE  = 8'hF4;
    localparam logic [7:0] RSP_ACK     = 8'hFA;
    localparam logic [7:0] RSP_BAT_OK  = 8'hAA;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_sync.sv
// Two-flop synchronizer for a raw PS/2 line; resets to the idle
// (released, high) level.
module ps2_sync (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/ps2_sync_edge.sv
// Synchronized PS/2 line plus a falling-edge strobe (previous 1,
// current 0).
module ps2_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o,
    output logic fall_o
);

    logic level;
    logic prev_q;

    ps2_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (d_i),
        .q_o (level)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= level;
        end
    end

    assign q_o    = level;
    assign fall_o = prev_q & ~level;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: clock inhibit, request-to-send,
// bit shifting on device clock edges, ACK check and watchdog.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 100_000_000,
    parameter int unsigned INHIBIT_US  = 120,
    parameter int unsigned TIMEOUT_MS  = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_err
);

    localparam int unsigned INH_CYC =
        CLK_FREQ_HZ / 1_000_000 * INHIBIT_US;
    localparam longint unsigned TO_CYC =
        64'(TIMEOUT_MS) * 64'(CLK_FREQ_HZ) / 1000;
    localparam int INH_W = $clog2(INH_CYC + 1);
    localparam int WD_W  = $clog2(TO_CYC + 1);
    localparam logic [INH_W-1:0] INH_MAX = INH_W'(INH_CYC - 1);
    localparam logic [WD_W-1:0]  WD_MAX  = WD_W'(TO_CYC - 1);

    logic clk_s;
    logic clk_fall;
    logic data_s;

    ps2_sync_edge u_clk_sync (
        .clk    (clk),
        .rst    (rst),
        .d_i    (ps2_clk_in),
        .q_o    (clk_s),
        .fall_o (clk_fall)
    );

    ps2_sync u_data_sync (
        .clk (clk),
        .rst (rst),
        .d_i (ps2_data_in),
        .q_o (data_s)
    );

    ps2_state_e       state_q, state_d;
    logic [9:0]       shift_q, shift_d;
    logic [3:0]       bit_q, bit_d;
    logic [INH_W-1:0] inh_q, inh_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic             clk_oe_q, clk_oe_d;
    logic             data_oe_q, data_oe_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_d     = bit_q;
        inh_d     = inh_q;
        wd_d      = wd_q;
        clk_oe_d  = clk_oe_q;
        data_oe_d = data_oe_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = 1'b0;

        // Watchdog wins over every other transition so done/err stay exclusive
        if (state_q != ST_IDLE && wd_q == WD_MAX) begin
            state_d   = ST_IDLE;
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            busy_d    = 1'b0;
            err_d     = 1'b1;
        end else begin
            if (state_q != ST_IDLE) begin
                wd_d = wd_q + WD_W'(1);
            end
            unique case (state_q)
                ST_IDLE: begin
                    if (tx_start) begin
                        shift_d  = {1'b1, odd_parity(tx_data), tx_data};
                        bit_d    = 4'd0;
                        inh_d    = '0;
                        wd_d     = '0;
                        clk_oe_d = 1'b1;
                        busy_d   = 1'b1;
                        state_d  = ST_INHIBIT;
                    end
                end
                ST_INHIBIT: begin
                    if (inh_q == INH_MAX) begin
                        data_oe_d = 1'b1;
                        state_d   = ST_RTS;
                    end else begin
                        inh_d = inh_q + INH_W'(1);
                    end
                end
                ST_RTS: begin
                    clk_oe_d = 1'b0;
                    state_d  = ST_SEND;
                end
                ST_SEND: begin
                    // Stop bit is a 1 shifted in, so edge 10 releases DATA
                    if (clk_fall) begin
                        data_oe_d = ~shift_q[0];
                        shift_d   = {1'b1, shift_q[9:1]};
                        bit_d     = bit_q + 4'd1;
                        if (bit_q == 4'd9) begin
                            state_d = ST_ACK;
                        end
                    end
                end
                ST_ACK: begin
                    if (clk_fall) begin
                        if (data_s) begin
                            data_oe_d = 1'b0;
                            busy_d    = 1'b0;
                            err_d     = 1'b1;
                            state_d   = ST_IDLE;
                        end else begin
                            state_d = ST_WAIT_IDLE;
                        end
                    end
                end
                ST_WAIT_IDLE: begin
                    if (clk_s && data_s) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d   = ST_IDLE;
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b0;
                    busy_d    = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            shift_q   <= '1;
            bit_q     <= '0;
            inh_q     <= '0;
            wd_q      <= '0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_q     <= bit_d;
            inh_q     <= inh_d;
            wd_q      <= wd_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;
    assign tx_busy     = busy_q;
    assign tx_done     = done_q;
    assign tx_err      = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain device model, event-scheduled
// expected outputs compared every cycle, plus literal frame checks.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    logic       clk;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       dev_clk;
    logic       dev_data;
    logic       ps2_clk_in;
    logic       ps2_data_in;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_err;

    ps2_host_tx #(
        .CLK_FREQ_HZ (1_000_000),
        .INHIBIT_US  (120),
        .TIMEOUT_MS  (15)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tx_data     (tx_data),
        .tx_start    (tx_start),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done),
        .tx_err      (tx_err)
    );

    // Wired-AND bus: either side may pull a line low
    assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
    assign ps2_data_in = dev_data & ~ps2_data_oe;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;
    int last_k = 0;

    typedef struct {
        int   at;
        int   idx;
        logic v;
    } ev_t;

    ev_t        ev_q[$];
    logic [4:0] exp_v = '0;
    logic [4:0] dut_v;

    assign dut_v = {tx_err, tx_done, tx_busy, ps2_data_oe, ps2_clk_oe};

    function automatic void sched(input int at, input int idx,
                                  input logic v);
        ev_t e;
        e.at  = at;
        e.idx = idx;
        e.v   = v;
        ev_q.push_back(e);
    endfunction

    always @(negedge clk) begin
        ev_t keep[$];
        if (rst) begin
            ev_q.delete();
            exp_v = '0;
        end else begin
            keep = {};
            foreach (ev_q[i]) begin
                if (ev_q[i].at == cyc) exp_v[ev_q[i].idx] = ev_q[i].v;
                else keep.push_back(ev_q[i]);
            end
            ev_q = keep;
        end
        checks++;
        if (dut_v !== exp_v) begin
            errors++;
            $display("FAIL cycle cyc=%0d {err,done,busy,doe,coe} got=%b exp=%b",
                     cyc, dut_v, exp_v);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Start sampled at the next edge: clk_oe alone 120 cycles, then
    // one cycle with both lines low, then clock released.
    task automatic start_tx(input logic [7:0] d);
        tx_data  = d;
        tx_start = 1'b1;
        last_k   = cyc;
        sched(cyc + 1, 0, 1'b1);
        sched(cyc + 1, 2, 1'b1);
        sched(cyc + 121, 1, 1'b1);
        sched(cyc + 122, 0, 1'b0);
        tick(1);
        tx_start = 1'b0;
    endtask

    // Host reacts to a line change three edges later (2 sync + 1 reg)
    task automatic device_frame(input logic [7:0] d, input bit ack,
                                input int abort_at, input bit inject,
                                output logic [9:0] got);
        int         n_wait;
        int         f;
        int         r;
        logic [9:0] bits;
        bits   = {1'b1, ~^d, d};
        got    = '0;
        n_wait = 0;
        while (!(ps2_clk_oe == 1'b0 && ps2_data_oe == 1'b1)
               && n_wait < 400) begin
            tick(1);
            n_wait++;
        end
        checks++;
        if (n_wait >= 400) begin
            errors++;
            $display("FAIL rts_wait got=timeout exp=request-to-send");
            return;
        end
        tick(5);
        for (int n = 1; n <= 10; n++) begin
            dev_clk = 1'b0;
            sched(cyc + 3, 1, ~bits[n-1]);
            tick(8);
            if (n == abort_at) begin
                rst = 1'b1;
                #1;
                chk("rst_immediate", {29'd0, tx_busy, ps2_data_oe, ps2_clk_oe}, 0);
                dev_clk  = 1'b1;
                dev_data = 1'b1;
                return;
            end
            dev_clk = 1'b1;
            tick(1);
            got[n-1] = ps2_data_in;
            if (inject && n == 4) begin
                tx_data  = CMD_RESET;
                tx_start = 1'b1;
                tick(1);
                tx_start = 1'b0;
                tick(7);
            end else begin
                tick(8);
            end
        end
        dev_data = ack ? 1'b0 : 1'b1;
        tick(4);
        dev_clk = 1'b0;
        f = cyc;
        if (!ack) begin
            sched(f + 3, 4, 1'b1);
            sched(f + 4, 4, 1'b0);
            sched(f + 3, 2, 1'b0);
        end
        tick(8);
        dev_clk = 1'b1;
        tick(3);
        dev_data = 1'b1;
        r = cyc;
        if (ack) begin
            sched(r + 3, 3, 1'b1);
            sched(r + 4, 3, 1'b0);
            sched(r + 3, 2, 1'b0);
        end
        tick(6);
    endtask

    logic [7:0] vd [4] = '{CMD_SET_LED, 8'h01, 8'h00, CMD_ENABLE};
    logic [9:0] vf [4] = '{10'b1_1_11101101, 10'b1_0_00000001,
                           10'b1_1_00000000, 10'b1_0_11110100};

    initial begin
        #1_000_000;
        $display("FAIL global_time got=stuck exp=finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        logic [9:0] got;
        int         k;
        rst      = 1'b1;
        tx_start = 1'b0;
        tx_data  = 8'h00;
        dev_clk  = 1'b1;
        dev_data = 1'b1;
        #2;
        chk("reset_state", {27'd0, dut_v}, 0);
        tick(3);
        rst = 1'b0;
        tick(2);

        for (int i = 0; i < 4; i++) begin
            start_tx(vd[i]);
            device_frame(vd[i], 1'b1, 0, i == 3, got);
            chk($sformatf("frame_%02h", vd[i]), {22'd0, got}, {22'd0, vf[i]});
        end

        start_tx(CMD_RESET);
        device_frame(CMD_RESET, 1'b0, 0, 1'b0, got);
        chk("nack_frame", {22'd0, got}, {22'd0, 10'b1_1_11111111});
        chk("nack_lines", {30'd0, ps2_data_oe, ps2_clk_oe}, 0);

        start_tx(CMD_SET_LED);
        k = last_k;
        sched(k + 15001, 4, 1'b1);
        sched(k + 15002, 4, 1'b0);
        sched(k + 15001, 2, 1'b0);
        sched(k + 15001, 1, 1'b0);
        while (cyc < k + 15000) tick(1);
        chk("wd_before", {30'd0, tx_busy, tx_err}, 32'd2);
        tick(1);
        chk("wd_fire", {27'd0, dut_v}, 32'h10);
        tick(1);
        chk("wd_after", {27'd0, dut_v}, 0);
        tick(3);

        start_tx(CMD_ENABLE);
        device_frame(CMD_ENABLE, 1'b1, 4, 1'b0, got);
        tick(1);
        rst = 1'b0;
        start_tx(CMD_SET_LED);
        device_frame(CMD_SET_LED, 1'b1, 0, 1'b0, got);
        chk("post_rst_frame", {22'd0, got}, {22'd0, 10'b1_1_11101101});
        tick(5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 Parameter CLK_FREQ_HZ, default 100_000_000, system clock frequency.
REQ-002 Parameter INHIBIT_US, default 120, clock-inhibit duration before request-to-send.
REQ-003 Parameter TIMEOUT_MS, default 15, whole-transaction watchdog.
REQ-004 clk  input  1  system clock; all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 tx_data  input  8  command byte to send to the keyboard.
REQ-007 tx_start  input  1  one-cycle request; tx_data is sampled in the same cycle.
REQ-008 ps2_clk_in  input  1  raw PS/2 CLK line level (asynchronous).
REQ-009 ps2_data_in  input  1  raw PS/2 DATA line level (asynchronous).
REQ-010 ps2_clk_oe  output  1  1 = drive PS/2 CLK low; 0 = release the line (open-drain).
REQ-011 ps2_data_oe  output  1  1 = drive PS/2 DATA low; 0 = release the line.
REQ-012 tx_busy  output  1  high from the cycle after an accepted tx_start until done or error.
REQ-013 tx_done  output  1  one-cycle pulse on successful ACK.
REQ-014 tx_err  output  1  one-cycle pulse on NACK or timeout.

Function
REQ-015 ps2_clk_in and ps2_data_in SHALL pass through a 2-flop synchronizer; a CLK falling edge is synced-previous=1 and synced-current=0.
REQ-016 States SHALL be IDLE, INHIBIT, RTS, SEND, ACK, WAIT_IDLE.
REQ-017 In IDLE, tx_start=1 SHALL latch tx_data, compute odd parity (parity = ~^tx_data), clear the bit counter, and move to INHIBIT.
REQ-018 INHIBIT SHALL hold ps2_clk_oe=1 for INHIBIT_CYCLES = CLK_FREQ_HZ/1_000_000*INHIBIT_US cycles, then set ps2_data_oe=1 (start bit) and enter RTS.
REQ-019 RTS SHALL keep ps2_data_oe=1 with ps2_clk_oe=1 for exactly one cycle, then release ps2_clk_oe and enter SEND.
REQ-020 In SEND, each device CLK falling edge n (n=1..10) SHALL drive the next bit: n=1..8 data bits LSB first, n=9 parity, n=10 stop (release DATA); ps2_data_oe = ~bit.
REQ-021 After the 10th edge SHALL enter ACK; on the 11th falling edge the synced DATA SHALL be sampled: 0 -> WAIT_IDLE, 1 -> tx_err pulse and IDLE.
REQ-022 WAIT_IDLE SHALL wait until synced CLK=1 and DATA=1, then pulse tx_done and return to IDLE.
REQ-023 The watchdog SHALL count from INHIBIT entry; reaching TIMEOUT_MS*CLK_FREQ_HZ/1000 cycles in any non-IDLE state SHALL release both lines, pulse tx_err, and return to IDLE.
REQ-024 tx_start while tx_busy=1 SHALL be ignored, with no effect on the byte in flight.
REQ-025 tx_done and tx_err SHALL never be asserted in the same cycle.
REQ-026 All outputs SHALL be registered; ps2_clk_oe and ps2_data_oe SHALL be 0 in IDLE.

Reset
REQ-027 rst=1 SHALL immediately force state IDLE and all outputs to 0 (lines released), and clear counters, shift register and synchronizers to 1 (line idle), including mid-transaction.
REQ-028 After rst deassertion, the first tx_start SHALL be accepted without any extra wait.

Structure
REQ-029 Shared package ps2_pkg SHALL hold the state enum and the command constants CMD_SET_LED=8'hED, CMD_RESET=8'hFF, CMD_ENABLE=8'hF4, RSP_ACK=8'hFA, RSP_BAT_OK=8'hAA.
REQ-030 Sub-module ps2_sync_edge (synchronizer plus falling-edge detect) SHALL be used for CLK; DATA SHALL use the same synchronizer without edge detect.

Verification (CLK_FREQ_HZ=1_000_000, INHIBIT_US=120 -> 120 cycles)
REQ-031 tx_data=8'hED with a device model clocking and ACKing -> clk_oe high 120 cycles, then bits 1,0,1,1,0,1,1,1, parity 1, stop released -> tx_done pulse, tx_err=0.
REQ-032 tx_data=8'h01 -> parity bit 0; tx_data=8'h00 -> parity bit 1; both end with tx_done.
REQ-033 Device leaves DATA high on the 11th edge -> tx_err pulse, both oe=0, return to IDLE.
REQ-034 Device never clocks -> tx_err exactly at 15000 cycles after start, both lines released.
REQ-035 Second tx_start=8'hFF during a transfer of 8'hF4 -> the byte on the wire stays 8'hF4; only one tx_done.
REQ-036 rst asserted after the 4th falling edge -> same-cycle clk_oe=data_oe=0, tx_busy=0; the next tx_start completes normally.
